// File: rtl/ifu_ysyx.sv
// Instruction fetch unit: owns the architectural PC, fetches over a valid/ready
// memory port, hands {inst, inst_pc, fetch_err} to decode and waits for commit.
module ifu_ysyx #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        EXEC
    } state_t;

    state_t state;

    logic pc_misaligned;
    assign pc_misaligned = (pc[1:0] != 2'b00);

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            inst      <= '0;
            inst_pc   <= '0;
            fetch_err <= 1'b0;
            inst_cnt  <= '0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    // A misaligned PC never reaches memory; decode sees a faulting slot.
                    if (pc_misaligned) begin
                        inst      <= '0;
                        fetch_err <= 1'b1;
                        inst_pc   <= pc;
                        state     <= HOLD;
                    end else if (imem_req_ready) begin
                        inst_pc <= pc;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst      <= imem_rsp_data;
                        fetch_err <= imem_rsp_err;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        inst_cnt <= inst_cnt + 32'd1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (pc_update) begin
                        pc    <= next_pc;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Handshake valids depend only on registered state, never on inputs.
    assign imem_req_valid = (state == REQ) && !pc_misaligned;
    assign imem_addr      = pc;
    assign inst_valid     = (state == HOLD);

endmodule

// File: tb/tb_ifu_ysyx.sv
// Directed bench for ifu_ysyx: stimulus pushes expected decode handoffs into a
// queue, an independent monitor pops and compares them at each handshake.
module tb_ifu_ysyx;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic [31:0] inst_cnt;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_cnt;
    logic [31:0] last_inst;
    logic [31:0] last_pc;

    ifu_ysyx #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc_update      (pc_update),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err),
        .inst_cnt       (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, then accepts it after req_stall cycles of
    // backpressure and answers after rsp_delay cycles in WAIT.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                            input int req_stall, input int rsp_delay);
        int n = 0;
        while (!imem_req_valid && n < 10) begin
            tick();
            n++;
        end
        check("req_valid_seen", {31'd0, imem_req_valid}, 32'd1);
        check("req_addr", imem_addr, addr);
        for (int i = 0; i < req_stall; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0000 + i;
            tick();
            imem_rsp_valid = 1'b0;
            check("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            check("req_hold_addr", imem_addr, addr);
            check("req_hold_no_inst", {31'd0, inst_valid}, 32'd0);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_req_drop", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < rsp_delay; i++) begin
            pc_update = 1'b1;
            next_pc   = 32'h1234_5678;
            tick();
            pc_update = 1'b0;
            check("wait_pc_stable", pc, addr);
            check("wait_no_inst", {31'd0, inst_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        sb_q.push_back('{inst: data, pc: addr, err: err, cnt: exp_cnt});
        last_inst = data;
        last_pc   = addr;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        check("inst_valid_after_rsp", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic do_misaligned(input logic [31:0] addr);
        check("misaligned_no_req", {31'd0, imem_req_valid}, 32'd0);
        sb_q.push_back('{inst: 32'd0, pc: addr, err: 1'b1, cnt: exp_cnt});
        last_inst = 32'd0;
        last_pc   = addr;
        tick();
        check("misaligned_inst_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    // Decode stalls for `stall` cycles with spurious commit strobes, then accepts.
    task automatic handoff(input int stall);
        for (int i = 0; i < stall; i++) begin
            pc_update = 1'b1;
            next_pc   = 32'hCAFE_0000;
            tick();
            pc_update = 1'b0;
            check("hold_valid", {31'd0, inst_valid}, 32'd1);
            check("hold_inst", inst, last_inst);
            check("hold_inst_pc", inst_pc, last_pc);
            check("hold_cnt", inst_cnt, exp_cnt);
            check("hold_pc", pc, last_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        check("handoff_valid_drop", {31'd0, inst_valid}, 32'd0);
        check("handoff_cnt", inst_cnt, exp_cnt);
    endtask

    task automatic commit(input logic [31:0] npc);
        pc_update = 1'b1;
        next_pc   = npc;
        tick();
        pc_update = 1'b0;
        check("commit_pc", pc, npc);
    endtask

    // Scoreboard monitor: compares every decode handshake against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_handoff", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_inst", inst, e.inst);
                    check("sb_inst_pc", inst_pc, e.pc);
                    check("sb_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                    check("sb_inst_cnt", inst_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        next_pc        = '0;
        pc_update      = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        exp_cnt        = '0;
        last_inst      = '0;
        last_pc        = '0;
        tick();
        tick();
        check("rst_pc", pc, RESET_PC);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_inst_cnt", inst_cnt, 32'd0);

        // Release: BOOT for one cycle, request in the second.
        rst = 1'b0;
        check("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req_valid}, 32'd1);

        do_fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0);
        handoff(0);
        commit(32'h8000_0004);

        do_fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 3, 2);
        handoff(4);
        commit(32'h8000_0102);

        do_misaligned(32'h8000_0102);
        handoff(1);
        commit(32'h8000_0200);

        do_fetch(32'h8000_0200, 32'hDEAD_BEEF, 1'b1, 0, 0);
        handoff(0);
        commit(32'h8000_0204);

        // Async reset while WAITing, with a response pending across the reset.
        check("pre_rst_req", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        #3;
        rst = 1'b1;
        #1;
        check("async_pc", pc, RESET_PC);
        check("async_cnt", inst_cnt, 32'd0);
        check("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("async_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("async_inst_pc", inst_pc, 32'd0);
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        tick();
        check("rerst_req", {31'd0, imem_req_valid}, 32'd1);
        check("rerst_no_inst", {31'd0, inst_valid}, 32'd0);
        imem_rsp_valid = 1'b0;
        do_fetch(32'h8000_0000, 32'h0000_0513, 1'b0, 1, 0);
        handoff(0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_ysyx.md
# ifu_ysyx

Instruction fetch unit for the NPC core. Holds the architectural PC register and fetches the instruction at that PC over a valid/ready instruction-memory interface. It hands the fetched instruction and its PC to the decode stage, then waits for the commit strobe. On that strobe it loads the next-PC value produced by the PC calculation block (`PC_ysyx.result`). It sits directly downstream of the PC calculation block and upstream of decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h80000000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `next_pc`  in  32  next PC from the PC calculation block.
- `pc_update`  in  1  commit strobe: current instruction has completed; load `next_pc`.
- `pc`  out  32  current architectural PC, also drives `PC_ysyx.pc`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  response valid.
- `imem_rsp_data`  in  32  fetched instruction word.
- `imem_rsp_err`  in  1  access fault with the response.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode accepts the instruction.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `fetch_err`  out  1  `inst` is invalid due to a misaligned PC or an access fault; qualified by `inst_valid`.
- `inst_cnt`  out  32  count of instructions handed to decode.

## Operation
The FSM has the states BOOT, REQ, WAIT, HOLD and EXEC.

- **BOOT**
  - Reset state; all outputs are inactive.
  - Next cycle goes to REQ.
- **REQ**
  - If `pc[1:0]` != 0, no request is issued. Latch `inst`=0 and `fetch_err`=1, then go to HOLD.
  - Otherwise `imem_req_valid`=1 with `imem_addr`=`pc`.
  - On `imem_req_valid & imem_req_ready`, go to WAIT.
- **WAIT**
  - On `imem_rsp_valid`, latch `inst`=`imem_rsp_data` and `fetch_err`=`imem_rsp_err`, then go to HOLD.
  - `imem_rsp_valid` in any other state is ignored.
- **HOLD**
  - `inst_valid`=1.
  - `inst`, `inst_pc` and `fetch_err` stay stable until the handshake.
  - On `inst_valid & inst_ready`: increment `inst_cnt` (wraps 0xFFFFFFFF→0) and go to EXEC.
- **EXEC**
  - Waits for `pc_update`. On `pc_update`, `pc`<=`next_pc` (all 32 bits, no masking) and go to REQ.
- `pc_update` outside EXEC is ignored; `pc` is unchanged.
- `inst_pc` is latched from `pc` when leaving REQ.
- `imem_req_valid`, once asserted, stays asserted with a stable `imem_addr` until accepted.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`, state=BOOT
  - `imem_req_valid`=0, `imem_addr`=`RESET_PC`
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_err`=0
  - `inst_cnt`=0
- `imem_req_valid` and `inst_valid` are decoded from registered state only, with no combinational path from any input.
- First request is presented in the second cycle after `rst` deasserts.
- Best-case latency from entering REQ to `inst_valid`:
  - Cycle 0: request accepted.
  - Cycle 1: response.
  - Cycle 2: `inst_valid`=1.
- The memory must not return the response in the same cycle as request acceptance.
- Misaligned PC: `inst_valid` is asserted the cycle after REQ.
- `pc` changes on the clock edge where `pc_update` is sampled in EXEC. A new request appears on the following cycle.
- **Reset mid-operation:**
  - Any state returns immediately to BOOT with the reset values.
  - A pending memory response after reset is ignored: the FSM is not in WAIT.

## Test plan
- **Reset fetch:** release `rst`, `imem_req_ready`=1, respond next cycle with 0x00000413 → `imem_addr`=0x80000000; `inst`=0x00000413, `inst_pc`=0x80000000, `inst_valid`=1 two cycles after acceptance.
- **Sequential commit:** after handoff, `next_pc`=0x80000004 and pulse `pc_update` → `pc`=0x80000004 next cycle, new request at 0x80000004, `inst_cnt`=1.
- **Backpressure:**
  - Hold `imem_req_ready`=0 for 3 cycles → `imem_req_valid` stays 1 with a stable address.
  - Hold `inst_ready`=0 for 4 cycles → `inst`/`inst_pc` stable, `inst_cnt` unchanged until the handshake.
- **Faults:**
  - `next_pc`=0x80000102 → no memory request; `inst_valid`=1 with `fetch_err`=1 and `inst`=0.
  - A response with `imem_rsp_err`=1 → `fetch_err`=1.
- **Spurious inputs:** `pc_update` pulsed in HOLD or WAIT, and `imem_rsp_valid` pulsed in REQ → `pc` and state unchanged.
- **Async reset:** assert `rst` mid-WAIT, between clock edges → outputs take reset values immediately; after release the fetch restarts at 0x80000000 and `inst_cnt`=0.
